// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared types and default widths for the ID/EX pipeline register and its helpers.
package id_ex_pkg;

  localparam int XLEN_DEF       = 64;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int ALUOP_W_DEF    = 2;
  localparam int CNT_W_DEF      = 16;

  typedef struct packed {
    logic                   alu_src;
    logic                   mem_to_reg;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic [ALUOP_W_DEF-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Instruction bus between pipeline stages. The producer drives it through the
// master modport and the consumer returns ready through the slave modport.
interface id_ex_pipe_reg_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2
);
  logic                  valid;
  logic                  ready;
  logic                  alu_src;
  logic                  mem_to_reg;
  logic                  reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic [ALUOP_W-1:0]    alu_op;
  logic                  uses_rs1;
  logic                  uses_rs2;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;
  logic [XLEN-1:0]       imm;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;

  modport master (
    output valid, alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op,
           uses_rs1, uses_rs2, rs1_data, rs2_data, imm, rs1, rs2, rd,
    input  ready
  );

  modport slave (
    input  valid, alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op,
           uses_rs1, uses_rs2, rs1_data, rs2_data, imm, rs1, rs2, rd,
    output ready
  );
endinterface

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is a source of the
// instruction in ID. Register 0 is hard-wired zero and never conflicts.
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  id_valid,
  input  logic                  id_uses_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic                  hazard
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    hazard  = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with handshake, stall, flush, load-use bubble insertion
// and a saturating bubble counter. ALUOP_W must match the alu_op width of ctrl_t.
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int ALUOP_W    = ALUOP_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  id_ex_pipe_reg_if.slave    id,
  id_ex_pipe_reg_if.master   ex,
  output logic               load_use_stall,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic                  vld_p1;
  ctrl_t                 ctrl_p1;
  logic                  uses_rs1_p1;
  logic                  uses_rs2_p1;
  logic [XLEN-1:0]       rs1_data_p1;
  logic [XLEN-1:0]       rs2_data_p1;
  logic [XLEN-1:0]       imm_p1;
  logic [REG_ADDR_W-1:0] rs1_p1;
  logic [REG_ADDR_W-1:0] rs2_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic [CNT_W-1:0]      cnt_p1;

  ctrl_t ctrl_id;
  logic  accept;
  logic  bubble;
  logic  drain;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == {CNT_W{1'b1}}) ? val : val + 1'b1;
  endfunction

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
    .ex_valid    (vld_p1),
    .ex_mem_read (ctrl_p1.mem_read),
    .ex_rd       (rd_p1),
    .id_valid    (id.valid),
    .id_uses_rs1 (id.uses_rs1),
    .id_rs1      (id.rs1),
    .id_uses_rs2 (id.uses_rs2),
    .id_rs2      (id.rs2),
    .hazard      (load_use_stall)
  );

  always_comb begin
    ctrl_id.alu_src    = id.alu_src;
    ctrl_id.mem_to_reg = id.mem_to_reg;
    ctrl_id.reg_write  = id.reg_write;
    ctrl_id.mem_read   = id.mem_read;
    ctrl_id.mem_write  = id.mem_write;
    ctrl_id.alu_op     = id.alu_op;
  end

  // Flush forces ready so decode can drop its instruction; the edge logic discards it.
  assign id.ready = flush | ((~vld_p1 | ex.ready) & ~load_use_stall);
  assign bubble   = load_use_stall & ex.ready;
  assign accept   = id.valid & id.ready;
  assign drain    = vld_p1 & ex.ready & ~id.valid;

  // ID -> EX stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      ctrl_p1     <= CTRL_NOP;
      uses_rs1_p1 <= 1'b0;
      uses_rs2_p1 <= 1'b0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      cnt_p1      <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_NOP;
    end else if (bubble) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_NOP;
      cnt_p1  <= sat_inc(cnt_p1);
    end else if (accept) begin
      vld_p1      <= 1'b1;
      ctrl_p1     <= ctrl_id;
      uses_rs1_p1 <= id.uses_rs1;
      uses_rs2_p1 <= id.uses_rs2;
      rs1_data_p1 <= id.rs1_data;
      rs2_data_p1 <= id.rs2_data;
      imm_p1      <= id.imm;
      rs1_p1      <= id.rs1;
      rs2_p1      <= id.rs2;
      rd_p1       <= id.rd;
    end else if (drain) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_NOP;
    end
  end

  assign ex.valid      = vld_p1;
  assign ex.alu_src    = ctrl_p1.alu_src;
  assign ex.mem_to_reg = ctrl_p1.mem_to_reg;
  assign ex.reg_write  = ctrl_p1.reg_write;
  assign ex.mem_read   = ctrl_p1.mem_read;
  assign ex.mem_write  = ctrl_p1.mem_write;
  assign ex.alu_op     = ctrl_p1.alu_op;
  assign ex.uses_rs1   = uses_rs1_p1;
  assign ex.uses_rs2   = uses_rs2_p1;
  assign ex.rs1_data   = rs1_data_p1;
  assign ex.rs2_data   = rs2_data_p1;
  assign ex.imm        = imm_p1;
  assign ex.rs1        = rs1_p1;
  assign ex.rs2        = rs2_p1;
  assign ex.rd         = rd_p1;
  assign bubble_cnt    = cnt_p1;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios plus a randomized run against an
// instruction-level model of the ID/EX slot (CNT_W=2 so saturation is reachable).
module tb_id_ex_pipe_reg;
  import id_ex_pkg::*;

  localparam int XLEN = 64;
  localparam int RAW  = 5;
  localparam int AOW  = 2;
  localparam int CW   = 2;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic load_use_stall;
  logic [CW-1:0] bubble_cnt;

  id_ex_pipe_reg_if #(.XLEN(XLEN), .REG_ADDR_W(RAW), .ALUOP_W(AOW)) id_bus ();
  id_ex_pipe_reg_if #(.XLEN(XLEN), .REG_ADDR_W(RAW), .ALUOP_W(AOW)) ex_bus ();

  id_ex_pipe_reg #(.XLEN(XLEN), .REG_ADDR_W(RAW), .ALUOP_W(AOW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .id             (id_bus),
    .ex             (ex_bus),
    .load_use_stall (load_use_stall),
    .bubble_cnt     (bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam ctrl_t C_ADD = '{alu_src: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b1,
                              mem_read: 1'b0, mem_write: 1'b0, alu_op: 2'b10};
  localparam ctrl_t C_LD  = '{alu_src: 1'b1, mem_to_reg: 1'b1, reg_write: 1'b1,
                              mem_read: 1'b1, mem_write: 1'b0, alu_op: 2'b00};

  // Reference: the single EX slot as an instruction record plus a bubble tally.
  typedef struct packed {
    ctrl_t           ctrl;
    logic [RAW-1:0]  rd;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
  } instr_t;

  bit     m_full;
  instr_t m_slot;
  int     m_bubbles;

  function automatic bit m_hazard();
    bit src_match;
    src_match = (id_bus.uses_rs1 && id_bus.rs1 == m_slot.rd) ||
                (id_bus.uses_rs2 && id_bus.rs2 == m_slot.rd);
    return m_full && m_slot.ctrl.mem_read && (m_slot.rd != 0) && id_bus.valid && src_match;
  endfunction

  function automatic bit m_ready();
    return flush || ((!m_full || ex_bus.ready) && !m_hazard());
  endfunction

  function automatic instr_t id_instr();
    instr_t t;
    t.ctrl     = '{alu_src: id_bus.alu_src, mem_to_reg: id_bus.mem_to_reg,
                   reg_write: id_bus.reg_write, mem_read: id_bus.mem_read,
                   mem_write: id_bus.mem_write, alu_op: id_bus.alu_op};
    t.rd       = id_bus.rd;
    t.rs1      = id_bus.rs1;
    t.rs2      = id_bus.rs2;
    t.imm      = id_bus.imm;
    t.rs1_data = id_bus.rs1_data;
    t.rs2_data = id_bus.rs2_data;
    return t;
  endfunction

  // Advance one clock; the model follows what the slot does with this cycle's inputs.
  task automatic tick();
    bit hz, rdy, consumed;
    hz  = m_hazard();
    rdy = m_ready();
    consumed = m_full && ex_bus.ready;
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_slot = '0; m_bubbles = 0;
    end else if (flush) begin
      m_full = 0; m_slot.ctrl = CTRL_NOP;
    end else if (hz && ex_bus.ready) begin
      m_full = 0; m_slot.ctrl = CTRL_NOP;
      if (m_bubbles < (1 << CW) - 1) m_bubbles++;
    end else if (id_bus.valid && rdy) begin
      m_full = 1; m_slot = id_instr();
    end else if (consumed && !id_bus.valid) begin
      m_full = 0; m_slot.ctrl = CTRL_NOP;
    end
    #1;
  endtask

  task automatic set_instr(input bit v, input ctrl_t c, input bit u1, input bit u2,
                           input logic [RAW-1:0] r1, input logic [RAW-1:0] r2,
                           input logic [RAW-1:0] d, input logic [XLEN-1:0] im);
    id_bus.valid      = v;
    id_bus.alu_src    = c.alu_src;
    id_bus.mem_to_reg = c.mem_to_reg;
    id_bus.reg_write  = c.reg_write;
    id_bus.mem_read   = c.mem_read;
    id_bus.mem_write  = c.mem_write;
    id_bus.alu_op     = c.alu_op;
    id_bus.uses_rs1   = u1;
    id_bus.uses_rs2   = u2;
    id_bus.rs1        = r1;
    id_bus.rs2        = r2;
    id_bus.rd         = d;
    id_bus.imm        = im;
    id_bus.rs1_data   = {$urandom, $urandom};
    id_bus.rs2_data   = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ex_bus.ready = 1'b0;
    set_instr(1, C_ADD, 1, 1, 5'd1, 5'd2, 5'd7, 64'h1234);
    tick();
    n_cmp++;
    if (ex_bus.valid !== 1'b1 || ex_bus.rd !== 5'd7) begin
      n_bad++; $display("FAIL reset_preload: valid=%b rd=%0d required valid=1 rd=7", ex_bus.valid, ex_bus.rd);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (ex_bus.valid !== 1'b0 || ex_bus.reg_write !== 1'b0 || ex_bus.alu_op !== 2'b00) begin
      n_bad++; $display("FAIL reset_ctrl: valid=%b reg_write=%b alu_op=%b required 0", ex_bus.valid, ex_bus.reg_write, ex_bus.alu_op);
    end
    n_cmp++;
    if (ex_bus.rd !== 5'd0 || ex_bus.imm !== 64'd0 || ex_bus.rs1_data !== 64'd0 || ex_bus.rs1 !== 5'd0) begin
      n_bad++; $display("FAIL reset_data: rd=%0d imm=%h rs1_data=%h required 0", ex_bus.rd, ex_bus.imm, ex_bus.rs1_data);
    end
    n_cmp++;
    if (bubble_cnt !== 2'd0) begin
      n_bad++; $display("FAIL reset_cnt: bubble_cnt=%0d required 0", bubble_cnt);
    end
    id_bus.valid = 1'b0;
  endtask

  task automatic test_streaming();
    ex_bus.ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      set_instr(1, C_ADD, 1, 1, 5'd10, 5'd11, 5'(k), 64'(16 * k));
      #1;
      n_cmp++;
      if (id_bus.ready !== 1'b1) begin
        n_bad++; $display("FAIL stream_ready[%0d]: id_ready=%b required 1", k, id_bus.ready);
      end
      tick();
      n_cmp++;
      if (ex_bus.valid !== 1'b1 || ex_bus.rd !== 5'(k) || ex_bus.imm !== 64'(16 * k) || ex_bus.reg_write !== 1'b1) begin
        n_bad++; $display("FAIL stream_out[%0d]: valid=%b rd=%0d imm=%h required valid=1 rd=%0d imm=%h",
                          k, ex_bus.valid, ex_bus.rd, ex_bus.imm, k, 16 * k);
      end
    end
    id_bus.valid = 1'b0;
    tick();
    n_cmp++;
    if (ex_bus.valid !== 1'b0 || ex_bus.reg_write !== 1'b0) begin
      n_bad++; $display("FAIL stream_drain: valid=%b reg_write=%b required 0", ex_bus.valid, ex_bus.reg_write);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_bus.ready = 1'b1;
    set_instr(1, C_LD, 1, 0, 5'd2, 5'd0, 5'd5, 64'h8);
    tick();
    set_instr(1, C_ADD, 1, 0, 5'd5, 5'd0, 5'd6, 64'h0);
    #1;
    n_cmp++;
    if (load_use_stall !== 1'b1 || id_bus.ready !== 1'b0) begin
      n_bad++; $display("FAIL lu_detect: stall=%b id_ready=%b required 1/0", load_use_stall, id_bus.ready);
    end
    tick();
    n_cmp++;
    if (ex_bus.valid !== 1'b0 || ex_bus.reg_write !== 1'b0 || ex_bus.mem_read !== 1'b0 || bubble_cnt !== 2'd1) begin
      n_bad++; $display("FAIL lu_bubble: valid=%b reg_write=%b mem_read=%b cnt=%0d required 0/0/0/1",
                        ex_bus.valid, ex_bus.reg_write, ex_bus.mem_read, bubble_cnt);
    end
    n_cmp++;
    if (load_use_stall !== 1'b0 || id_bus.ready !== 1'b1) begin
      n_bad++; $display("FAIL lu_release: stall=%b id_ready=%b required 0/1", load_use_stall, id_bus.ready);
    end
    tick();
    n_cmp++;
    if (ex_bus.valid !== 1'b1 || ex_bus.rd !== 5'd6 || bubble_cnt !== 2'd1) begin
      n_bad++; $display("FAIL lu_follow: valid=%b rd=%0d cnt=%0d required 1/6/1", ex_bus.valid, ex_bus.rd, bubble_cnt);
    end
    set_instr(1, C_LD, 1, 0, 5'd2, 5'd0, 5'd0, 64'h8);
    tick();
    set_instr(1, C_ADD, 1, 0, 5'd0, 5'd0, 5'd6, 64'h0);
    #1;
    n_cmp++;
    if (load_use_stall !== 1'b0 || id_bus.ready !== 1'b1) begin
      n_bad++; $display("FAIL lu_rd0: stall=%b id_ready=%b required 0/1", load_use_stall, id_bus.ready);
    end
    tick();
    n_cmp++;
    if (ex_bus.valid !== 1'b1 || ex_bus.rd !== 5'd6 || bubble_cnt !== 2'd1) begin
      n_bad++; $display("FAIL lu_rd0_load: valid=%b rd=%0d cnt=%0d required 1/6/1", ex_bus.valid, ex_bus.rd, bubble_cnt);
    end
  endtask

  task automatic test_backpressure();
    ex_bus.ready = 1'b0;
    set_instr(1, C_ADD, 1, 1, 5'd1, 5'd2, 5'd11, 64'h99);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (id_bus.ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_ready[%0d]: id_ready=%b required 0", k, id_bus.ready);
      end
      tick();
      n_cmp++;
      if (ex_bus.valid !== 1'b1 || ex_bus.rd !== 5'd6 || ex_bus.reg_write !== 1'b1) begin
        n_bad++; $display("FAIL bp_hold[%0d]: valid=%b rd=%0d required 1/6", k, ex_bus.valid, ex_bus.rd);
      end
    end
    ex_bus.ready = 1'b1;
    set_instr(1, C_LD, 1, 0, 5'd3, 5'd0, 5'd9, 64'h20);
    tick();
    ex_bus.ready = 1'b0;
    set_instr(1, C_ADD, 0, 1, 5'd0, 5'd9, 5'd12, 64'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (load_use_stall !== 1'b1 || id_bus.ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_lu_comb[%0d]: stall=%b id_ready=%b required 1/0", k, load_use_stall, id_bus.ready);
      end
      tick();
      n_cmp++;
      if (ex_bus.valid !== 1'b1 || ex_bus.rd !== 5'd9 || ex_bus.mem_read !== 1'b1 || bubble_cnt !== 2'd1) begin
        n_bad++; $display("FAIL bp_lu_hold[%0d]: valid=%b rd=%0d mem_read=%b cnt=%0d required 1/9/1/1",
                          k, ex_bus.valid, ex_bus.rd, ex_bus.mem_read, bubble_cnt);
      end
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    #1;
    n_cmp++;
    if (id_bus.ready !== 1'b1 || load_use_stall !== 1'b1) begin
      n_bad++; $display("FAIL flush_comb: id_ready=%b stall=%b required 1/1", id_bus.ready, load_use_stall);
    end
    tick();
    flush = 1'b0;
    n_cmp++;
    if (ex_bus.valid !== 1'b0 || ex_bus.mem_read !== 1'b0 || ex_bus.reg_write !== 1'b0 || ex_bus.alu_src !== 1'b0) begin
      n_bad++; $display("FAIL flush_ctrl: valid=%b mem_read=%b reg_write=%b required 0", ex_bus.valid, ex_bus.mem_read, ex_bus.reg_write);
    end
    n_cmp++;
    if (ex_bus.rd === 5'd12 || bubble_cnt !== 2'd1) begin
      n_bad++; $display("FAIL flush_discard: rd=%0d cnt=%0d required rd!=12 cnt=1", ex_bus.rd, bubble_cnt);
    end
    id_bus.valid = 1'b0;
  endtask

  task automatic test_saturation();
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    do_reset();
    ex_bus.ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_instr(1, C_LD, 0, 0, 5'd0, 5'd0, 5'd3, 64'h4);
      tick();
      set_instr(1, C_ADD, 1, 0, 5'd3, 5'd0, 5'd4, 64'h0);
      tick();
      n_cmp++;
      if (bubble_cnt !== 2'(exp_cnt[k]) || ex_bus.valid !== 1'b0) begin
        n_bad++; $display("FAIL sat[%0d]: cnt=%0d valid=%b required cnt=%0d valid=0", k, bubble_cnt, ex_bus.valid, exp_cnt[k]);
      end
    end
    id_bus.valid = 1'b0;
  endtask

  task automatic test_random();
    instr_t got;
    ctrl_t  c;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      c = ctrl_t'($urandom);
      set_instr($urandom_range(0, 9) < 7, c, 1'($urandom), 1'($urandom),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                {$urandom, $urandom});
      ex_bus.ready = $urandom_range(0, 9) < 7;
      flush        = $urandom_range(0, 9) == 0;
      rst          = $urandom_range(0, 39) == 0;
      #1;
      n_cmp++;
      if (load_use_stall !== m_hazard() || id_bus.ready !== m_ready()) begin
        n_bad++; $display("FAIL rnd_comb[%0d]: stall=%b id_ready=%b required %b/%b",
                          cyc, load_use_stall, id_bus.ready, m_hazard(), m_ready());
      end
      tick();
      got.ctrl     = '{alu_src: ex_bus.alu_src, mem_to_reg: ex_bus.mem_to_reg, reg_write: ex_bus.reg_write,
                       mem_read: ex_bus.mem_read, mem_write: ex_bus.mem_write, alu_op: ex_bus.alu_op};
      got.rd       = ex_bus.rd;
      got.rs1      = ex_bus.rs1;
      got.rs2      = ex_bus.rs2;
      got.imm      = ex_bus.imm;
      got.rs1_data = ex_bus.rs1_data;
      got.rs2_data = ex_bus.rs2_data;
      n_cmp++;
      if (ex_bus.valid !== m_full || got !== m_slot || bubble_cnt !== 2'(m_bubbles)) begin
        n_bad++; $display("FAIL rnd_state[%0d]: valid=%b ctrl=%b rd=%0d cnt=%0d required valid=%b ctrl=%b rd=%0d cnt=%0d",
                          cyc, ex_bus.valid, got.ctrl, got.rd, bubble_cnt, m_full, m_slot.ctrl, m_slot.rd, m_bubbles);
      end
    end
    rst   = 1'b0;
    flush = 1'b0;
    id_bus.valid = 1'b0;
  endtask

  initial begin
    m_full = 0; m_slot = '0; m_bubbles = 0;
    rst = 1'b1;
    flush = 1'b0;
    ex_bus.ready = 1'b0;
    set_instr(0, CTRL_NOP, 0, 0, '0, '0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_streaming();
    test_load_use();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
